pkt_ring_writer: RTL and testbench

- Sits directly downstream of the PDU generator's output queues.
- Consumes packet flits (flit_lite_t) and per-packet descriptors (pkt_meta_t: pkt_queue_id, size in flits).
- Per packet: looks up the packet queue's ring-buffer tail and head, admits or drops the packet, and streams admitted flits as slot-addressed writes to the PCIe DMA stage.
- After each admitted packet, publishes the new tail for that queue.

---
 rtl/pkt_ring_writer_pkg.sv | 32 +++
 rtl/pkt_ring_writer_if.sv | 42 ++++
 rtl/pkt_ring_writer_ptr_table_ram.sv | 22 ++
 rtl/pkt_ring_writer.sv | 141 ++++++++++++++
 tb/tb_pkt_ring_writer.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pkt_ring_writer_pkg.sv
// Shared types for the packet ring writer: flit/descriptor formats, ring-slot and FSM types.
package pkt_ring_writer_pkg;

  localparam int unsigned FLOW_IDX_WIDTH = 4;
  localparam int unsigned RB_SIZE_LOG    = 12;
  localparam int unsigned PKT_SIZE_WIDTH = 16;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
  } flit_lite_t;

  typedef struct packed {
    logic [FLOW_IDX_WIDTH-1:0] pkt_queue_id;
    logic [PKT_SIZE_WIDTH-1:0] size;
  } pkt_meta_t;

  typedef logic [RB_SIZE_LOG-1:0]    ring_slot_t;
  typedef logic [FLOW_IDX_WIDTH-1:0] queue_id_t;

  typedef enum logic [2:0] {
    StInit,
    StIdle,
    StLookup,
    StCheck,
    StWrite,
    StDrop,
    StUpdate
  } state_e;

endpackage

// File: rtl/pkt_ring_writer_if.sv
// Bundles the flit/descriptor inputs, head writes, slot writes, tail updates and status.
interface pkt_ring_writer_if import pkt_ring_writer_pkg::*; ();

  flit_lite_t   in_pkt_data;
  logic         in_pkt_valid;
  logic         in_pkt_ready;
  pkt_meta_t    in_meta_data;
  logic         in_meta_valid;
  logic         in_meta_ready;
  logic         head_wr_valid;
  queue_id_t    head_wr_queue_id;
  ring_slot_t   head_wr_value;
  logic [511:0] out_wr_data;
  queue_id_t    out_wr_queue_id;
  ring_slot_t   out_wr_slot;
  logic         out_wr_sop;
  logic         out_wr_eop;
  logic         out_wr_valid;
  logic         out_wr_ready;
  logic         tail_upd_valid;
  queue_id_t    tail_upd_queue_id;
  ring_slot_t   tail_upd_value;
  logic         init_done;
  logic [31:0]  dropped_pkts;

  modport master (
    output in_pkt_data, in_pkt_valid, in_meta_data, in_meta_valid,
    output head_wr_valid, head_wr_queue_id, head_wr_value, out_wr_ready,
    input  in_pkt_ready, in_meta_ready, out_wr_data, out_wr_queue_id, out_wr_slot,
    input  out_wr_sop, out_wr_eop, out_wr_valid, tail_upd_valid, tail_upd_queue_id,
    input  tail_upd_value, init_done, dropped_pkts
  );

  modport slave (
    input  in_pkt_data, in_pkt_valid, in_meta_data, in_meta_valid,
    input  head_wr_valid, head_wr_queue_id, head_wr_value, out_wr_ready,
    output in_pkt_ready, in_meta_ready, out_wr_data, out_wr_queue_id, out_wr_slot,
    output out_wr_sop, out_wr_eop, out_wr_valid, tail_upd_valid, tail_upd_queue_id,
    output tail_upd_value, init_done, dropped_pkts
  );

endinterface

// File: rtl/pkt_ring_writer_ptr_table_ram.sv
// Simple dual-port pointer table: one write port, one read port with 1-cycle latency.
module pkt_ring_writer_ptr_table_ram #(
  parameter int unsigned AddrWidth = 4,
  parameter int unsigned DataWidth = 12
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] waddr,
  input  logic [DataWidth-1:0] wdata,
  input  logic [AddrWidth-1:0] raddr,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [2**AddrWidth];

  // Contents are cleared by the owner's init sweep, so no reset here.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/pkt_ring_writer.sv
// Admits or drops each packet against its queue's ring free space and streams admitted
// flits as slot-addressed writes, publishing the advanced tail after each packet.
module pkt_ring_writer import pkt_ring_writer_pkg::*; (
  input  logic               clk,
  input  logic               rst,
  pkt_ring_writer_if.slave   bus
);

  localparam int unsigned NbQueues = 2**FLOW_IDX_WIDTH;

  state_e                    state;
  queue_id_t                 init_addr;
  pkt_meta_t                 meta;
  ring_slot_t                tail;
  logic [PKT_SIZE_WIDTH-1:0] cnt;
  ring_slot_t                cnt_slot;
  ring_slot_t                head_rd, tail_rd, free_slots;
  logic                      pkt_acc, meta_acc;
  logic                      head_we, tail_we;
  queue_id_t                 head_waddr, tail_waddr;
  ring_slot_t                head_wdata, tail_wdata;

  assign cnt_slot = cnt[RB_SIZE_LOG-1:0];

  always_comb begin
    bus.in_meta_ready = (state == StIdle);
    bus.in_pkt_ready  = 1'b0;
    if (state == StWrite)     bus.in_pkt_ready = !bus.out_wr_valid || bus.out_wr_ready;
    else if (state == StDrop) bus.in_pkt_ready = 1'b1;
    pkt_acc    = bus.in_pkt_valid && bus.in_pkt_ready;
    meta_acc   = bus.in_meta_valid && bus.in_meta_ready;
    free_slots = head_rd - tail_rd - ring_slot_t'(1);
    // Head writes from software are dropped while the init sweep owns the port.
    head_we    = (state == StInit) || bus.head_wr_valid;
    head_waddr = (state == StInit) ? init_addr : bus.head_wr_queue_id;
    head_wdata = (state == StInit) ? '0 : bus.head_wr_value;
    tail_we    = (state == StInit) || (state == StUpdate);
    tail_waddr = (state == StInit) ? init_addr : meta.pkt_queue_id;
    tail_wdata = (state == StInit) ? '0 : tail + cnt_slot;
  end

  pkt_ring_writer_ptr_table_ram #(
    .AddrWidth(FLOW_IDX_WIDTH),
    .DataWidth(RB_SIZE_LOG)
  ) u_head_table (
    .clk  (clk),
    .we   (head_we),
    .waddr(head_waddr),
    .wdata(head_wdata),
    .raddr(meta.pkt_queue_id),
    .rdata(head_rd)
  );

  pkt_ring_writer_ptr_table_ram #(
    .AddrWidth(FLOW_IDX_WIDTH),
    .DataWidth(RB_SIZE_LOG)
  ) u_tail_table (
    .clk  (clk),
    .we   (tail_we),
    .waddr(tail_waddr),
    .wdata(tail_wdata),
    .raddr(meta.pkt_queue_id),
    .rdata(tail_rd)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= StInit;
      init_addr             <= '0;
      meta                  <= '0;
      tail                  <= '0;
      cnt                   <= '0;
      bus.out_wr_data       <= '0;
      bus.out_wr_queue_id   <= '0;
      bus.out_wr_slot       <= '0;
      bus.out_wr_sop        <= 1'b0;
      bus.out_wr_eop        <= 1'b0;
      bus.out_wr_valid      <= 1'b0;
      bus.tail_upd_valid    <= 1'b0;
      bus.tail_upd_queue_id <= '0;
      bus.tail_upd_value    <= '0;
      bus.init_done         <= 1'b0;
      bus.dropped_pkts      <= '0;
    end else begin
      bus.tail_upd_valid <= 1'b0;
      if (bus.out_wr_valid && bus.out_wr_ready) bus.out_wr_valid <= 1'b0;
      case (state)
        StInit: begin
          init_addr <= init_addr + queue_id_t'(1);
          if (init_addr == queue_id_t'(NbQueues - 1)) begin
            bus.init_done <= 1'b1;
            state         <= StIdle;
          end
        end
        StIdle: begin
          if (meta_acc) begin
            meta  <= bus.in_meta_data;
            state <= StLookup;
          end
        end
        StLookup: state <= StCheck;
        StCheck: begin
          tail <= tail_rd;
          cnt  <= '0;
          if (meta.size == '0 || meta.size > PKT_SIZE_WIDTH'(free_slots)) state <= StDrop;
          else                                                           state <= StWrite;
        end
        StWrite: begin
          if (pkt_acc) begin
            bus.out_wr_valid    <= 1'b1;
            bus.out_wr_data     <= bus.in_pkt_data.data;
            bus.out_wr_sop      <= bus.in_pkt_data.sop;
            bus.out_wr_eop      <= bus.in_pkt_data.eop;
            bus.out_wr_queue_id <= meta.pkt_queue_id;
            bus.out_wr_slot     <= tail + cnt_slot;
            cnt                 <= cnt + 1'b1;
            // Pulse the new tail while UPDATE commits it to the table.
            if (bus.in_pkt_data.eop) begin
              bus.tail_upd_valid    <= 1'b1;
              bus.tail_upd_queue_id <= meta.pkt_queue_id;
              bus.tail_upd_value    <= tail + cnt_slot + ring_slot_t'(1);
              state                 <= StUpdate;
            end
          end
        end
        StDrop: begin
          if (pkt_acc && bus.in_pkt_data.eop) begin
            if (bus.dropped_pkts != '1) bus.dropped_pkts <= bus.dropped_pkts + 32'd1;
            state <= StIdle;
          end
        end
        StUpdate: state <= StIdle;
        default:  state <= StInit;
      endcase
    end
  end

  cnt_matches_size: assert property (@(posedge clk) disable iff (rst)
    (state == StWrite && pkt_acc && bus.in_pkt_data.eop) |-> (cnt + 1'b1 == meta.size));

endmodule

// File: tb/tb_pkt_ring_writer.sv
// Scoreboard bench for pkt_ring_writer: directed packets push expected writes/tail updates,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_pkt_ring_writer;
  import pkt_ring_writer_pkg::*;

  localparam int Timeout = 50;

  typedef struct packed {
    logic [511:0] data;
    queue_id_t    qid;
    ring_slot_t   slot;
    logic         sop;
    logic         eop;
  } wr_exp_t;

  typedef struct packed {
    queue_id_t  qid;
    ring_slot_t val;
  } upd_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pkt_ring_writer_if bus ();

  pkt_ring_writer dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  wr_exp_t  wr_q[$];
  upd_exp_t upd_q[$];
  int       checks = 0;
  int       errors = 0;
  bit       toggle_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_data(input string name, input logic [511:0] act,
                            input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out after %0d cycles, expected handshake", name, Timeout);
  endtask

  function automatic logic [511:0] mk_data(input queue_id_t q, input int idx);
    logic [31:0] tag;
    tag = {8'hA5, 8'(q), 16'(idx)};
    return {16{tag}};
  endfunction

  // Downstream ready: steady high, or toggling every cycle while toggle_en is set.
  initial begin
    bus.out_wr_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_wr_ready = toggle_en ? ~bus.out_wr_ready : 1'b1;
    end
  end

  // Monitor: compares presented writes and tail updates against the scoreboard.
  logic         stalled = 1'b0;
  logic [511:0] held_data;
  wr_exp_t      we;
  upd_exp_t     ue;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", 64'(bus.out_wr_valid), 64'd1);
        check_data("stall_data_held", bus.out_wr_data, held_data);
      end
      if (bus.out_wr_valid && bus.out_wr_ready) begin
        if (wr_q.size() == 0) begin
          check("unexpected_wr_slot", 64'(bus.out_wr_slot), 64'hFFFF_FFFF);
        end else begin
          we = wr_q.pop_front();
          check_data("wr_data", bus.out_wr_data, we.data);
          check("wr_qid", 64'(bus.out_wr_queue_id), 64'(we.qid));
          check("wr_slot", 64'(bus.out_wr_slot), 64'(we.slot));
          check("wr_sop", 64'(bus.out_wr_sop), 64'(we.sop));
          check("wr_eop", 64'(bus.out_wr_eop), 64'(we.eop));
        end
      end
      stalled   = bus.out_wr_valid && !bus.out_wr_ready;
      held_data = bus.out_wr_data;
      if (bus.tail_upd_valid) begin
        if (upd_q.size() == 0) begin
          check("unexpected_tail_upd", 64'(bus.tail_upd_value), 64'hFFFF_FFFF);
        end else begin
          ue = upd_q.pop_front();
          check("tail_upd_qid", 64'(bus.tail_upd_queue_id), 64'(ue.qid));
          check("tail_upd_value", 64'(bus.tail_upd_value), 64'(ue.val));
        end
      end
    end
  end

  // All driving tasks are entered and left 1 time unit after a rising edge.
  task automatic head_wr(input queue_id_t q, input ring_slot_t v);
    bus.head_wr_valid    = 1'b1;
    bus.head_wr_queue_id = q;
    bus.head_wr_value    = v;
    @(posedge clk);
    #1;
    bus.head_wr_valid = 1'b0;
  endtask

  task automatic send_meta(input queue_id_t q, input int size);
    int n = 0;
    bus.in_meta_valid             = 1'b1;
    bus.in_meta_data.pkt_queue_id = q;
    bus.in_meta_data.size         = PKT_SIZE_WIDTH'(size);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_meta_ready && n < Timeout);
    if (!bus.in_meta_ready) timeout_fail("meta_handshake");
    @(posedge clk);
    #1;
    bus.in_meta_valid = 1'b0;
  endtask

  task automatic send_flit(input logic [511:0] d, input logic sop, input logic eop);
    int n = 0;
    bus.in_pkt_valid     = 1'b1;
    bus.in_pkt_data.data = d;
    bus.in_pkt_data.sop  = sop;
    bus.in_pkt_data.eop  = eop;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_pkt_ready && n < Timeout);
    if (!bus.in_pkt_ready) timeout_fail("flit_handshake");
    @(posedge clk);
    #1;
    bus.in_pkt_valid = 1'b0;
  endtask

  // Sends a whole packet; if admitted, pushes its expected writes and tail update.
  task automatic send_pkt(input queue_id_t q, input int n, input bit admit, input int start);
    logic [511:0] d;
    send_meta(q, n);
    for (int i = 0; i < n; i++) begin
      d = mk_data(q, i);
      if (admit) wr_q.push_back('{d, q, ring_slot_t'(start + i), i == 0, i == n - 1});
      send_flit(d, i == 0, i == n - 1);
    end
    if (admit) upd_q.push_back('{q, ring_slot_t'(start + n)});
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    while (!bus.init_done && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!bus.init_done) timeout_fail(name);
  endtask

  initial begin
    int n;
    logic [511:0] d;
    bus.in_pkt_valid     = 1'b0;
    bus.in_pkt_data      = '0;
    bus.in_meta_valid    = 1'b0;
    bus.in_meta_data     = '0;
    bus.head_wr_valid    = 1'b0;
    bus.head_wr_queue_id = '0;
    bus.head_wr_value    = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_wr_valid", 64'(bus.out_wr_valid), 64'd0);
    check("rst_tail_upd_valid", 64'(bus.tail_upd_valid), 64'd0);
    check("rst_init_done", 64'(bus.init_done), 64'd0);
    check("rst_dropped", 64'(bus.dropped_pkts), 64'd0);
    check("rst_meta_ready", 64'(bus.in_meta_ready), 64'd0);
    check("rst_pkt_ready", 64'(bus.in_pkt_ready), 64'd0);
    rst = 1'b0;

    // Init sweep takes one cycle per queue.
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.init_done) break;
      if (bus.in_meta_ready) check("meta_ready_during_init", 64'(bus.in_meta_ready), 64'd0);
    end
    check("init_latency", 64'(n), 64'(2**FLOW_IDX_WIDTH));

    // Queue 3: plain 4-flit packet from slot 0.
    head_wr(4'd3, 12'd100);
    send_pkt(4'd3, 4, 1'b1, 0);

    // Queue 5: advance tail to 4094, then a packet wrapping the ring.
    head_wr(4'd5, 12'd4095);
    send_pkt(4'd5, 2047, 1'b1, 0);
    send_pkt(4'd5, 2047, 1'b1, 2047);
    head_wr(4'd5, 12'd10);
    send_pkt(4'd5, 4, 1'b1, 4094);

    // Queue 7: 4096 flits cannot fit (free 4095), all flits consumed, nothing written.
    send_pkt(4'd7, 4096, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("dropped_after_oversize", 64'(bus.dropped_pkts), 64'd1);

    // Queue 9: back-to-back packets under downstream backpressure.
    head_wr(4'd9, 12'd100);
    toggle_en = 1'b1;
    send_pkt(4'd9, 2, 1'b1, 0);
    send_pkt(4'd9, 2, 1'b1, 2);
    repeat (6) @(posedge clk);
    toggle_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Queue 3 (tail 4): reset partway through a packet.
    send_meta(4'd3, 4);
    for (int i = 0; i < 2; i++) begin
      d = mk_data(4'd3, i);
      wr_q.push_back('{d, 4'd3, ring_slot_t'(4 + i), i == 0, 1'b0});
      send_flit(d, i == 0, 1'b0);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_out_wr_valid", 64'(bus.out_wr_valid), 64'd0);
    check("midrst_pkt_ready", 64'(bus.in_pkt_ready), 64'd0);
    check("midrst_meta_ready", 64'(bus.in_meta_ready), 64'd0);
    check("midrst_init_done", 64'(bus.init_done), 64'd0);
    check("midrst_dropped", 64'(bus.dropped_pkts), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    // Ignored during init; if applied, head=1 would leave no room and drop the next packet.
    head_wr(4'd3, 12'd1);
    wait_init("reinit_done");
    send_pkt(4'd3, 2, 1'b1, 0);

    n = 0;
    while ((wr_q.size() != 0 || upd_q.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    check("wr_queue_drained", 64'(wr_q.size()), 64'd0);
    check("upd_queue_drained", 64'(upd_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
